// File: rtl/scazator_serial_8b.sv
// Bit-serial subtractor: in0 - in1 - borrow_in, one bit per clock, LSB first.
// Define SCAZATOR_OVERFLOW_EN to add the signed-overflow output.
module scazator_serial_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
`ifdef SCAZATOR_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-2:0] p;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nx;
  logic             d;
  logic             last;
  logic             accept;

  assign d      = a[0] ^ b[0] ^ br;
  assign br_nx  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
  assign sh     = {d, p};
  assign last   = (cnt == LAST);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  // IDLE and DONE both accept a new request
  assign accept = start && (state != SHIFT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      p          <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      out        <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a   <= in0;
      b   <= in1;
      br  <= borrow_in;
      p   <= '0;
      cnt <= '0;
    end else if (busy) begin
      a   <= a >> 1;
      b   <= b >> 1;
      p   <= sh[WIDTH-1:1];
      br  <= br_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        out        <= sh;
        borrow_out <= br_nx;
      end
    end
  end

`ifdef SCAZATOR_OVERFLOW_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= in0[WIDTH-1];
      b_msb <= in1[WIDTH-1];
    end else if (busy && last) begin
      overflow <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: doc/scazator_serial_8b.md
Name: scazator_serial_8b

Overview:
- Bit-serial subtractor: the inverse of the 8-bit parallel adder.
- Computes in0 - in1 - borrow_in, one bit per clock, LSB first, over a start/done handshake.
- Gives a small-area alternative to the parallel adder/subtractor path.
- Sits beside the adder in the datapath and is controlled by the local sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits (valid range ≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- borrow_in  input  1  incoming borrow, subtracted from the difference.
- in0  input  WIDTH  minuend.
- in1  input  WIDTH  subtrahend.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- out  output  WIDTH  difference register.
- borrow_out  output  1  final borrow: 1 when in0 < in1 + borrow_in (unsigned).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, out=0, borrow_out=0. Internal shift registers, bit counter and borrow flop are all cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: latch in0→A, in1→B, borrow_in→br; counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), at each edge:
  - d = A[0]^B[0]^br
  - br ← (~A[0]&B[0]) | (~(A[0]^B[0])&br)
  - A, B shift right by 1; d is shifted into the MSB of the partial-result register P.
  - counter increments.
- Leaving SHIFT: on the edge that processes bit WIDTH-1, load out←final P (including that bit) and borrow_out←final br; go to DONE.
- DONE (busy=0, done=1 for exactly one cycle), at the next edge:
  - start=1: latch new operands and go to SHIFT (back-to-back accepted).
  - otherwise: go to IDLE.
- Latency:
  - start sampled at edge E0.
  - busy=1 during the WIDTH cycles after E0.
  - done=1 and out valid in the cycle following edge E(WIDTH), i.e. WIDTH+1 clocks after the start edge.
  - Throughput is one operation per WIDTH+1 cycles.
- out/borrow_out:
  - Hold the previous result throughout SHIFT; they change only on the completing edge.
  - Held indefinitely after DONE until the next completion.
- start while busy=1: ignored; the operands in flight are unaffected.
- Input operands are sampled only at the accepting edge; later changes to in0/in1/borrow_in have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. {borrow_out,out} equals the two's-complement (WIDTH+1)-bit result of in0 - in1 - borrow_in.

Optional Feature:
- Macro: SCAZATOR_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), a signed-overflow flag.
  - The block latches A[WIDTH-1] and B[WIDTH-1] at start.
  - On completion: overflow ← (a_msb != b_msb) && (d_msb != a_msb), where d_msb is the final result MSB.
  - Updated and held with the same timing as out; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start with in0=0x05, in1=0x03, borrow_in=0 → done pulse 9 cycles after the start edge; out=0x02, borrow_out=0; busy high for exactly 8 cycles.
- in0=0x03, in1=0x05, borrow_in=0 → out=0xFE, borrow_out=1. Then in0=0x00, in1=0x00, borrow_in=1 → out=0xFF, borrow_out=1.
- in0=0xFF, in1=0xFF, borrow_in=1 → out=0xFF, borrow_out=1. With SCAZATOR_OVERFLOW_EN: in0=0x80, in1=0x01, borrow_in=0 → out=0x7F, overflow=1; in0=0x10, in1=0x01 → overflow=0.
- Start 0x40-0x10; pulse start with 0x01-0x01 during cycle 3 of busy → second request ignored; out=0x30. Then start held high in the DONE cycle with 0x09-0x04 → accepted back-to-back; out=0x05 nine cycles later.
- Start 0xAA-0x55, assert rst_n=0 at busy cycle 4 → outputs clear immediately (asynchronously); no done pulse. After release, start 0x10-0x20 → out=0xF0, borrow_out=1.
